// File: rtl/fir_bank_pkg.sv
// Shared types and width helpers for the parametrised FIR filter bank.
// The state encoding and derived widths live here so the top and lanes agree.
package fir_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_t;

  localparam int DRAIN_CYCLES = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  function automatic int addr_width(input int taps);
    return (clog2(taps / 2) < 1) ? 1 : clog2(taps / 2);
  endfunction

  function automatic longint round_bias(input int shift, input int round_en);
    if (round_en != 0 && shift > 0) return longint'(1) << (shift - 1);
    return 0;
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One filter channel: coefficient/product pipeline stages, wide accumulator,
// round-half-up scaling with saturation and a sticky overflow flag.
module fir_mac_lane
  import fir_bank_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 18,
  parameter int NUM_TAPS  = 128,
  parameter int OUT_SHIFT = 16,
  parameter int ROUND     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     p1_en,
  input  logic                     p2_en,
  input  logic                     p3_en,
  input  logic                     out_en,
  input  logic signed [DATA_W-1:0] x_a,
  input  logic signed [DATA_W-1:0] x_b,
  input  logic [2*COEF_W-1:0]      coef_pair,
  output logic signed [DATA_W-1:0] dout,
  output logic                     ovf
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NUM_TAPS);
  localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(round_bias(OUT_SHIFT, ROUND));
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [COEF_W-1:0] c_a, c_b;
  logic signed [PROD_W-1:0] p_a, p_b;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    biased, scaled;
  logic                     sat_hi, sat_lo;

  // One extra bit of headroom so the rounding bias can never wrap the sum.
  always_comb begin
    biased = (ACC_W+1)'(acc) + RND;
    scaled = biased >>> OUT_SHIFT;
    sat_hi = (scaled > MAX_V);
    sat_lo = (scaled < MIN_V);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c_a  <= '0;
      c_b  <= '0;
      p_a  <= '0;
      p_b  <= '0;
      acc  <= '0;
      dout <= '0;
      ovf  <= 1'b0;
    end else begin
      if (p1_en) begin
        c_a <= coef_pair[COEF_W-1:0];
        c_b <= coef_pair[2*COEF_W-1:COEF_W];
      end
      if (p2_en) begin
        p_a <= PROD_W'(x_a) * PROD_W'(c_a);
        p_b <= PROD_W'(x_b) * PROD_W'(c_b);
      end
      if (clear)
        acc <= '0;
      else if (p3_en)
        acc <= acc + ACC_W'(p_a) + ACC_W'(p_b);
      if (out_en) begin
        if (sat_hi)
          dout <= MAX_V[DATA_W-1:0];
        else if (sat_lo)
          dout <= MIN_V[DATA_W-1:0];
        else
          dout <= scaled[DATA_W-1:0];
        if (sat_hi || sat_lo) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_bank_param.sv
// Multi-channel FIR bank: shared delay line, sequencing FSM, tap-pair mux and
// ready/valid handshake feeding NUM_CH MAC lanes, two taps per clock.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | din_ready=1, waiting for a sample; accept shifts delay line
// ST_ISSUE | drive coeff_addr k = 0..NUM_TAPS/2-1, one per cycle
// ST_DRAIN | DRAIN_CYCLES cycles while the MAC pipeline empties
// ST_OUT   | register scaled outputs; dout_valid pulses next cycle
module fir_bank_param
  import fir_bank_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int NUM_TAPS  = 128,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 18,
  parameter int OUT_SHIFT = 16,
  parameter int ROUND     = 1,
  localparam int AW       = addr_width(NUM_TAPS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [DATA_W-1:0]   din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [AW-1:0]              coeff_addr,
  input  logic [NUM_CH*2*COEF_W-1:0] coeff_bus,
  output logic [NUM_CH*DATA_W-1:0]   dout,
  output logic                       dout_valid,
  output logic [NUM_CH-1:0]          ovf,
  output logic                       overrun
);

  localparam int HALF = NUM_TAPS / 2;
  localparam logic [AW-1:0] LAST_K     = AW'(HALF - 1);
  localparam logic [1:0]    DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  fir_state_t state, state_nxt;
  logic [1:0] drain_cnt;
  logic       accept;
  logic       out_en;
  logic [AW-1:0] addr_d1;
  logic       v1, v2, v3;
  logic signed [DATA_W-1:0] x [NUM_TAPS];
  logic signed [DATA_W-1:0] x_a, x_b;

  assign din_ready = (state == ST_IDLE);
  assign accept    = din_valid && din_ready;
  assign out_en    = (state == ST_OUT);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: if (coeff_addr == LAST_K) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'd0) state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // v1..v3 track the ROM-read, product and accumulate stages for address k.
  always_ff @(posedge clock) begin
    if (reset) begin
      coeff_addr <= '0;
      drain_cnt  <= '0;
      addr_d1    <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= out_en;
      if (din_valid && !din_ready) overrun <= 1'b1;
      if (accept)
        coeff_addr <= '0;
      else if (state == ST_ISSUE && coeff_addr != LAST_K)
        coeff_addr <= coeff_addr + 1'b1;
      if (state == ST_ISSUE)
        drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 1'b1;
      addr_d1 <= coeff_addr;
      v1 <= (state == ST_ISSUE);
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) x[i] <= '0;
      x_a <= '0;
      x_b <= '0;
    end else begin
      if (accept) begin
        x[0] <= din;
        for (int i = 1; i < NUM_TAPS; i++) x[i] <= x[i-1];
      end
      if (v1) begin
        x_a <= x[{addr_d1, 1'b0}];
        x_b <= x[{addr_d1, 1'b1}];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    fir_mac_lane #(
      .DATA_W   (DATA_W),
      .COEF_W   (COEF_W),
      .NUM_TAPS (NUM_TAPS),
      .OUT_SHIFT(OUT_SHIFT),
      .ROUND    (ROUND)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .clear    (accept),
      .p1_en    (v1),
      .p2_en    (v2),
      .p3_en    (v3),
      .out_en   (out_en),
      .x_a      (x_a),
      .x_b      (x_b),
      .coef_pair(coeff_bus[c*2*COEF_W +: 2*COEF_W]),
      .dout     (dout[c*DATA_W +: DATA_W]),
      .ovf      (ovf[c])
    );
  end

endmodule

// File: tb/tb_fir_bank_param.sv
// Directed bench for fir_bank_param: default-parameter bank plus a one-channel
// truncating (ROUND=0) instance sharing the same input stream.
module tb_fir_bank_param;

  localparam int NUM_CH   = 8;
  localparam int NUM_TAPS = 128;
  localparam int DATA_W   = 16;
  localparam int COEF_W   = 18;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic signed [DATA_W-1:0] din = '0;
  logic din_valid = 1'b0;

  logic                       din_ready, dout_valid, overrun;
  logic [5:0]                 coeff_addr;
  logic [NUM_CH*2*COEF_W-1:0] coeff_bus;
  logic [NUM_CH*DATA_W-1:0]   dout;
  logic [NUM_CH-1:0]          ovf;

  logic                       din_ready_t, dout_valid_t, overrun_t;
  logic [5:0]                 coeff_addr_t;
  logic [2*COEF_W-1:0]        coeff_bus_t;
  logic [DATA_W-1:0]          dout_t;
  logic [0:0]                 ovf_t;

  logic signed [COEF_W-1:0] coef [NUM_CH][NUM_TAPS];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fir_bank_param dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .coeff_addr(coeff_addr), .coeff_bus(coeff_bus),
    .dout(dout), .dout_valid(dout_valid), .ovf(ovf), .overrun(overrun)
  );

  fir_bank_param #(.NUM_CH(1), .ROUND(0)) dut_t (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_t), .coeff_addr(coeff_addr_t), .coeff_bus(coeff_bus_t),
    .dout(dout_t), .dout_valid(dout_valid_t), .ovf(ovf_t), .overrun(overrun_t)
  );

  // Coefficient ROM with a one-cycle registered read.
  always @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      coeff_bus[c*2*COEF_W +: COEF_W]          <= coef[c][2*coeff_addr];
      coeff_bus[c*2*COEF_W+COEF_W +: COEF_W]   <= coef[c][2*coeff_addr+1];
    end
    coeff_bus_t[COEF_W-1:0]        <= coef[0][2*coeff_addr_t];
    coeff_bus_t[2*COEF_W-1:COEF_W] <= coef[0][2*coeff_addr_t+1];
  end

  // tap_sel < 0: every tap gets v; otherwise only tap tap_sel gets v.
  task automatic set_taps(input int tap_sel, input int v);
    for (int c = 0; c < NUM_CH; c++)
      for (int t = 0; t < NUM_TAPS; t++)
        coef[c][t] = (tap_sel < 0 || t == tap_sel) ? COEF_W'(v) : '0;
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] splat(input int v);
    logic [NUM_CH*DATA_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  // Sends one sample; lat is the cycle of dout_valid relative to acceptance
  // (-1 if none within the budget). Optionally injects a second din_valid or
  // a reset pulse at a given cycle after acceptance.
  task automatic send_sample(input int v, input int inj_cycle, input int inj_v,
                             input int rst_cycle, output int lat,
                             output logic [NUM_CH*DATA_W-1:0] o,
                             output logic [DATA_W-1:0] o_t,
                             output logic rdy_inj, output logic rdy_rst,
                             output logic [NUM_CH*DATA_W-1:0] o_rst);
    int n;
    int w;
    lat = -1; o = '0; o_t = '0; rdy_inj = 1'b1; rdy_rst = 1'b0; o_rst = '1;
    w = 0;
    while (!din_ready && w < 200) begin @(negedge clock); w++; end
    din = DATA_W'(v);
    din_valid = 1'b1;
    @(negedge clock);
    din_valid = 1'b0;
    n = 1;
    while (n < 150) begin
      if (n == inj_cycle) begin
        rdy_inj = din_ready;
        din = DATA_W'(inj_v);
        din_valid = 1'b1;
      end
      if (n == rst_cycle) reset = 1'b1;
      if (dout_valid) begin
        lat = n; o = dout; o_t = dout_t;
        break;
      end
      @(negedge clock);
      n++;
      din_valid = 1'b0;
      if (reset) begin
        reset = 1'b0;
        rdy_rst = din_ready;
        o_rst = dout;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b want 0", dout_valid); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf got %h want 0", ovf); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
    checks++; if (coeff_addr !== '0) begin errors++; $display("FAIL reset_coeff_addr got %h want 0", coeff_addr); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_impulse();
    int lat;
    logic [NUM_CH*DATA_W-1:0] o, o_rst, expv;
    logic [DATA_W-1:0] o_t;
    logic ri, rr;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int t = 0; t < NUM_TAPS; t++) coef[c][t] = COEF_W'((c + 1) << 12);
      expv[c*DATA_W +: DATA_W] = DATA_W'(c + 1);
    end
    for (int s = 0; s < NUM_TAPS; s++) begin
      send_sample((s == 0) ? 16 : 0, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
      if (s == 0) begin
        checks++; if (lat !== 69) begin errors++; $display("FAIL impulse_latency got %0d want 69", lat); end
      end
      checks++;
      if (o !== expv) begin errors++; $display("FAIL impulse_out[%0d] got %h want %h", s, o, expv); end
    end
    send_sample(0, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (o !== '0) begin errors++; $display("FAIL impulse_shifted_out got %h want 0", o); end
  endtask

  task automatic test_gain();
    int dv[3] = '{1000, -1000, -32768};
    int lat;
    logic [NUM_CH*DATA_W-1:0] o, o_rst;
    logic [DATA_W-1:0] o_t;
    logic ri, rr;
    set_taps(0, 65536);
    for (int i = 0; i < 3; i++) begin
      send_sample(dv[i], -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
      checks++;
      if (o !== splat(dv[i])) begin errors++; $display("FAIL gain[%0d] got %h want %h", dv[i], o, splat(dv[i])); end
    end
  endtask

  task automatic test_rounding();
    int dv[2]    = '{3, -3};
    int exp_r[2] = '{2, -1};
    int exp_t[2] = '{1, -2};
    int lat;
    logic [NUM_CH*DATA_W-1:0] o, o_rst;
    logic [DATA_W-1:0] o_t;
    logic ri, rr;
    set_taps(0, 32768);
    for (int i = 0; i < 2; i++) begin
      send_sample(dv[i], -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
      checks++;
      if (o !== splat(exp_r[i])) begin errors++; $display("FAIL round_half_up[%0d] got %h want %h", dv[i], o, splat(exp_r[i])); end
      checks++;
      if (o_t !== DATA_W'(exp_t[i])) begin errors++; $display("FAIL round_trunc[%0d] got %h want %h", dv[i], o_t, DATA_W'(exp_t[i])); end
    end
  endtask

  task automatic test_overrun();
    int lat;
    logic [NUM_CH*DATA_W-1:0] o, o_rst;
    logic [DATA_W-1:0] o_t;
    logic ri, rr;
    set_taps(0, 65536);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_before got %b want 0", overrun); end
    send_sample(7, 10, 5, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (ri !== 1'b0) begin errors++; $display("FAIL overrun_ready got %b want 0", ri); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
    checks++; if (lat !== 69) begin errors++; $display("FAIL overrun_latency got %0d want 69", lat); end
    checks++; if (o !== splat(7)) begin errors++; $display("FAIL overrun_out got %h want %h", o, splat(7)); end
    set_taps(1, 65536);
    send_sample(0, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (o !== splat(7)) begin errors++; $display("FAIL overrun_dropped got %h want %h", o, splat(7)); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [NUM_CH*DATA_W-1:0] o, o_rst;
    logic [DATA_W-1:0] o_t;
    logic ri, rr;
    set_taps(-1, 65536);
    send_sample(50, -1, 0, 30, lat, o, o_t, ri, rr, o_rst);
    checks++; if (rr !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", rr); end
    checks++; if (o_rst !== '0) begin errors++; $display("FAIL midrst_dout got %h want 0", o_rst); end
    checks++; if (lat !== -1) begin errors++; $display("FAIL midrst_no_valid got %0d want -1", lat); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b want 0", overrun); end
    send_sample(100, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (o !== splat(100)) begin errors++; $display("FAIL midrst_fresh got %h want %h", o, splat(100)); end
    send_sample(0, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (o !== splat(100)) begin errors++; $display("FAIL midrst_second got %h want %h", o, splat(100)); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [NUM_CH*DATA_W-1:0] o, o_rst;
    logic [DATA_W-1:0] o_t;
    logic ri, rr;
    set_taps(-1, 131071);
    checks++; if (ovf !== '0) begin errors++; $display("FAIL sat_ovf_before got %h want 0", ovf); end
    for (int s = 0; s < NUM_TAPS; s++) send_sample(32767, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (o !== splat(32767)) begin errors++; $display("FAIL sat_pos got %h want %h", o, splat(32767)); end
    checks++; if (ovf !== '1) begin errors++; $display("FAIL sat_ovf_pos got %h want ff", ovf); end
    for (int s = 0; s < NUM_TAPS; s++) send_sample(-32768, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (o !== splat(-32768)) begin errors++; $display("FAIL sat_neg got %h want %h", o, splat(-32768)); end
    send_sample(0, -1, 0, -1, lat, o, o_t, ri, rr, o_rst);
    checks++; if (o !== splat(-32768)) begin errors++; $display("FAIL sat_after_zero got %h want %h", o, splat(-32768)); end
    checks++; if (ovf !== '1) begin errors++; $display("FAIL sat_ovf_sticky got %h want ff", ovf); end
  endtask

  initial begin
    set_taps(-1, 0);
    test_reset();
    test_impulse();
    test_gain();
    test_rounding();
    test_overrun();
    test_reset_mid_run();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
